// File: rtl/diffeq_pkg.sv
// Shared types for the diffeq job feeder: job record, feeder state encoding, packed job width.
package diffeq_pkg;

  localparam int JOB_WIDTH = 32;
  localparam int JOB_BITS  = 5 * JOB_WIDTH;

  typedef struct packed {
    logic [JOB_WIDTH-1:0] x;
    logic [JOB_WIDTH-1:0] y;
    logic [JOB_WIDTH-1:0] u;
    logic [JOB_WIDTH-1:0] a;
    logic [JOB_WIDTH-1:0] dx;
  } job_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    RETIRE = 2'd3
  } state_e;

endpackage

// File: rtl/diffeq_job_fifo.sv
// DEPTH x DW register FIFO; full/empty come from extended-pointer compare so they are purely registered state.
module diffeq_job_fifo
  import diffeq_pkg::*;
#(
  parameter int DW    = JOB_BITS,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full)  wr_d = wr_q + 1'b1;
    if (pop  && !empty) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);

endmodule

// File: rtl/diffeq_job_feeder.sv
// Buffers job descriptors and launches them one at a time into the diffeq solver.
// Define DIFFEQ_FEEDER_TIMEOUT_EN to add a RUN watchdog that retires a stuck job.
//
// state  | meaning
// IDLE   | solver held in reset, waiting for a queued job
// LAUNCH | FIFO head copied to sol_* and popped, solver still in reset
// RUN    | solver running on held sol_*, waiting for sol_done
// RETIRE | solver back in reset for one cycle before the next job
module diffeq_job_feeder
  import diffeq_pkg::*;
#(
  parameter int WIDTH   = JOB_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_u,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_dx,
  output logic [WIDTH-1:0] sol_x,
  output logic [WIDTH-1:0] sol_y,
  output logic [WIDTH-1:0] sol_u,
  output logic [WIDTH-1:0] sol_a,
  output logic [WIDTH-1:0] sol_dx,
  output logic             sol_rst,
  input  logic             sol_done,
  output logic             busy,
  output logic [15:0]      job_count,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int JW = 5 * WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("diffeq_job_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  state_e        state_q, state_d;
  logic [JW-1:0] job_q, job_d, fifo_rdata;
  logic          sol_rst_q, sol_rst_d, busy_q, busy_d, ovf_q, ovf_d, rdy_q, rdy_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          fifo_full, fifo_empty, pop;
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_err_q, tmo_err_d;
`endif

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_q & ~fifo_full;
  assign pop      = (state_q == LAUNCH);

  diffeq_job_fifo #(.DW(JW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (in_valid & in_ready),
    .wdata ({in_x, in_y, in_u, in_a, in_dx}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    sol_rst_d = sol_rst_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rdy_d     = 1'b1;
    ovf_d     = ovf_q | (in_valid & ~in_ready);
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = LAUNCH;
          busy_d  = 1'b1;
        end
      end
      LAUNCH: begin
        job_d     = fifo_rdata;
        sol_rst_d = 1'b0;
        state_d   = RUN;
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
        tmo_d     = TW'(TIMEOUT - 1);
`endif
      end
      RUN: begin
        if (sol_done) begin
          cnt_d     = cnt_q + 16'd1;
          sol_rst_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = RETIRE;
        end
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
        else if (tmo_q == '0) begin
          tmo_err_d = 1'b1;
          sol_rst_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = RETIRE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
      RETIRE: begin
        if (!fifo_empty) begin
          state_d = LAUNCH;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      job_q     <= '0;
      sol_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rdy_q     <= 1'b0;
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      sol_rst_q <= sol_rst_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rdy_q     <= rdy_d;
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  assign sol_x     = job_q[5*WIDTH-1 -: WIDTH];
  assign sol_y     = job_q[4*WIDTH-1 -: WIDTH];
  assign sol_u     = job_q[3*WIDTH-1 -: WIDTH];
  assign sol_a     = job_q[2*WIDTH-1 -: WIDTH];
  assign sol_dx    = job_q[WIDTH-1:0];
  assign sol_rst   = sol_rst_q;
  assign busy      = busy_q;
  assign job_count = cnt_q;
  assign overflow  = ovf_q;
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_diffeq_job_feeder.sv
// Self-checking bench for diffeq_job_feeder: directed vector table, hand-written corner sequences,
// and randomized traffic against a cycle-stamped queue model of the launch/retire rules.
module tb_diffeq_job_feeder;
  import diffeq_pkg::*;

  localparam int W   = 32;
  localparam int D   = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        sol_done = 1'b0;
  job_t        job_in = '0;
  logic        in_ready, sol_rst, busy, overflow, timeout_err;
  logic [W-1:0] sol_x, sol_y, sol_u, sol_a, sol_dx;
  logic [15:0] job_count;

  always #5 clk = ~clk;

  diffeq_job_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(job_in.x), .in_y(job_in.y), .in_u(job_in.u), .in_a(job_in.a), .in_dx(job_in.dx),
    .sol_x(sol_x), .sol_y(sol_y), .sol_u(sol_u), .sol_a(sol_a), .sol_dx(sol_dx),
    .sol_rst(sol_rst), .sol_done(sol_done), .busy(busy), .job_count(job_count),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: queued jobs, the job on the solver ports, and the cycle numbers of
  // the next scheduled launch / retire.
  job_t        mq[$];
  job_t        cur;
  bit          in_run, rdy_en, ovf, tmo;
  int          launch_cyc, retire_cyc, run_len;
  logic [15:0] exp_cnt;

  task automatic model_reset();
    mq.delete();
    cur = '0; in_run = 0; rdy_en = 0; ovf = 0; tmo = 0;
    launch_cyc = -1; retire_cyc = -1; run_len = 0; exp_cnt = '0;
  endtask

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Check the current cycle against the model, advance the model across the edge, then the DUT.
  task automatic step(output bit acc);
    bit exp_rdy, idle_now;
    int sz;
    sz      = mq.size();
    exp_rdy = rdy_en && (sz < D);
    chk("in_ready",    160'(in_ready),    160'(exp_rdy));
    chk("sol_rst",     160'(sol_rst),     160'(!in_run));
    chk("busy",        160'(busy),        160'(in_run || launch_cyc == cyc));
    chk("job_count",   160'(job_count),   160'(exp_cnt));
    chk("overflow",    160'(overflow),    160'(ovf));
    chk("timeout_err", 160'(timeout_err), 160'(tmo));
    chk("sol_job",     {sol_x, sol_y, sol_u, sol_a, sol_dx}, cur);

    idle_now = !in_run && launch_cyc != cyc && retire_cyc != cyc;
    if (launch_cyc == cyc) begin
      cur = mq.pop_front();
      in_run = 1; run_len = 0;
    end else if (in_run) begin
      if (sol_done) begin
        exp_cnt = exp_cnt + 16'd1; in_run = 0; retire_cyc = cyc + 1;
      end
`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
      else if (run_len == TMO - 1) begin
        tmo = 1; in_run = 0; retire_cyc = cyc + 1;
      end
`endif
      else run_len++;
    end
    if (retire_cyc == cyc && sz > 0) launch_cyc = cyc + 1;
    if (idle_now && sz > 0)          launch_cyc = cyc + 1;
    if (in_valid && !exp_rdy) ovf = 1;
    acc = in_valid && exp_rdy;
    if (acc) mq.push_back(job_in);

    @(posedge clk); #1;
    cyc++;
    rdy_en = 1;
  endtask

  function automatic job_t rand_job();
    job_t j;
    j.x = $urandom(); j.y = $urandom(); j.u = $urandom(); j.a = $urandom(); j.dx = $urandom();
    return j;
  endfunction

  typedef struct {
    bit          v, done;
    bit          rdy, rst, bsy;
    logic [31:0] sx, sa, sdx;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(bit v, bit done, bit rdy, bit rst, bit bsy,
                              logic [31:0] sa, logic [31:0] sdx, logic [15:0] cnt);
    vec_t r;
    r.v = v; r.done = done; r.rdy = rdy; r.rst = rst; r.bsy = bsy;
    r.sx = 32'd0; r.sa = sa; r.sdx = sdx; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    bit acc;
    int dc;
    bit prev_rst;

    // Single job X=0 Y=1 U=1 A=4 DX=1, done 8 cycles into RUN, then a stray done in IDLE.
    tbl[0] = mk(1, 0, 1, 1, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 1, 1, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 3; i <= 10; i++) tbl[i] = mk(0, 0, 1, 0, 1, 4, 1, 0);
    tbl[11] = mk(0, 1, 1, 0, 1, 4, 1, 0);
    tbl[12] = mk(0, 0, 1, 1, 0, 4, 1, 1);
    tbl[13] = mk(0, 0, 1, 1, 0, 4, 1, 1);
    tbl[14] = mk(0, 1, 1, 1, 0, 4, 1, 1);
    tbl[15] = mk(0, 0, 1, 1, 0, 4, 1, 1);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  160'(in_ready),  160'(0));
    chk("rst_sol_rst",   160'(sol_rst),   160'(1));
    chk("rst_busy",      160'(busy),      160'(0));
    chk("rst_job_count", 160'(job_count), 160'(0));
    chk("rst_sol_x",     160'(sol_x),     160'(0));
    reset = 1'b1;
    step(acc);

    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].v;
      sol_done = tbl[i].done;
      job_in.x = 32'd0; job_in.y = 32'd1; job_in.u = 32'd1; job_in.a = 32'd4; job_in.dx = 32'd1;
      chk("vec_in_ready",  160'(in_ready),  160'(tbl[i].rdy));
      chk("vec_sol_rst",   160'(sol_rst),   160'(tbl[i].rst));
      chk("vec_busy",      160'(busy),      160'(tbl[i].bsy));
      chk("vec_sol_x",     160'(sol_x),     160'(tbl[i].sx));
      chk("vec_sol_a",     160'(sol_a),     160'(tbl[i].sa));
      chk("vec_sol_dx",    160'(sol_dx),    160'(tbl[i].sdx));
      chk("vec_job_count", 160'(job_count), 160'(tbl[i].cnt));
      step(acc);
    end
    in_valid = 0; sol_done = 0;

    // Burst of DEPTH+1 jobs while one is running: the 5th is blocked until a slot frees.
    job_in = rand_job(); in_valid = 1; step(acc); in_valid = 0;
    repeat (3) step(acc);
    for (int k = 0; k < 5; k++) begin
      job_in = rand_job();
      in_valid = 1;
      if (k == 4) chk("burst_5th_blocked", 160'(in_ready), 160'(0));
      step(acc);
      if (k == 4) chk("burst_overflow", 160'(overflow), 160'(1));
      for (int t = 0; t < 20 && !acc; t++) begin
        sol_done = (t == 0);
        step(acc);
      end
      sol_done = 0;
      if (!acc) chk("burst_accept_wait", 160'(0), 160'(1));
    end
    in_valid = 0;

    dc = -1;
    for (int t = 0; t < 80; t++) begin
      sol_done = in_run && (run_len == 3);
      if (sol_done && mq.size() > 0) dc = cyc;
      prev_rst = sol_rst;
      step(acc);
      if (dc >= 0 && prev_rst && !sol_rst) begin
        chk("launch_gap", 160'(cyc - dc), 160'(3));
        dc = -1;
      end
    end
    sol_done = 0;
    chk("burst_drained", 160'(mq.size() + int'(in_run)), 160'(0));

    // Reset during RUN with three jobs queued.
    for (int k = 0; k < 4; k++) begin
      job_in = rand_job(); in_valid = 1; step(acc);
    end
    in_valid = 0;
    repeat (2) step(acc);
    chk("pre_reset_running", 160'(sol_rst), 160'(0));
    #2 reset = 1'b0;
    #1;
    chk("midrst_sol_rst",   160'(sol_rst),   160'(1));
    chk("midrst_busy",      160'(busy),      160'(0));
    chk("midrst_in_ready",  160'(in_ready),  160'(0));
    chk("midrst_job_count", 160'(job_count), 160'(0));
    @(posedge clk);
    @(posedge clk); #1;
    cyc += 2;
    reset = 1'b1;
    model_reset();
    repeat (10) step(acc);

`ifdef DIFFEQ_FEEDER_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      job_in = rand_job(); in_valid = 1; step(acc);
    end
    in_valid = 0;
    repeat (45) step(acc);
    chk("timeout_flag",  160'(timeout_err), 160'(1));
    chk("timeout_count", 160'(job_count),   160'(0));
`endif

    for (int t = 0; t < 1500; t++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      job_in   = rand_job();
      if ($urandom_range(0, 9) == 0) job_in.a = job_in.x;
      sol_done = ($urandom_range(0, 5) == 0);
      step(acc);
    end
    in_valid = 0; sol_done = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
